// File: rtl/program_memory_loadable_if.sv
// Fetch and bootload bundle for program_memory_loadable; master is the PC/loader side, slave the memory.
// parity_err exists only when PROG_MEM_PARITY_EN is defined.
interface program_memory_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              ready;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;
`ifdef PROG_MEM_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output rd_en, rd_addr, ld_start, ld_valid, ld_data, ld_last,
        input  rd_data, rd_valid, rd_err, ready, ld_ready, ld_done, ld_count
`ifdef PROG_MEM_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  rd_en, rd_addr, ld_start, ld_valid, ld_data, ld_last,
        output rd_data, rd_valid, rd_err, ready, ld_ready, ld_done, ld_count
`ifdef PROG_MEM_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/program_memory_loadable.sv
// Loadable program store: zero-fills after reset, streaming bootloader, 1-cycle registered fetch with range check.
// Latency: fetch result 1 cycle after rd_en; ld_done 1 cycle after the final accepted word.
// Backpressure: fetches only while ready (IDLE), words only while ld_ready (LOAD); optional PROG_MEM_PARITY_EN adds parity_err.
module program_memory_loadable #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    program_memory_loadable_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [MEM_W-1:0] mem [0:DEPTH-1];

    logic [1:0]       state;
    logic [IDX_W-1:0] clr_ptr;
    logic [IDX_W-1:0] wr_ptr;

    logic             in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [MEM_W-1:0] rd_word;
    logic             fetch;
    logic             ld_accept;
    logic             ld_end;

    logic             mem_we;
    logic [IDX_W-1:0] mem_wa;
    logic [MEM_W-1:0] mem_wd;

    assign bus.ready    = (state == ST_IDLE);
    assign bus.ld_ready = (state == ST_LOAD);

    assign in_range  = ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_idx    = bus.rd_addr[IDX_W-1:0];
    assign rd_word   = mem[rd_idx];
    // ld_start wins over a same-cycle fetch; that fetch is simply dropped.
    assign fetch     = (state == ST_IDLE) && bus.rd_en && !bus.ld_start;
    assign ld_accept = (state == ST_LOAD) && bus.ld_valid;
    assign ld_end    = ld_accept && (bus.ld_last || (wr_ptr == LAST_IDX));

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_ptr;
        mem_wd = '0;
        case (state)
            ST_CLEAR: mem_we = 1'b1;
            ST_LOAD: begin
                mem_we = bus.ld_valid;
                mem_wa = wr_ptr;
`ifdef PROG_MEM_PARITY_EN
                mem_wd = {^bus.ld_data, bus.ld_data};
`else
                mem_wd = bus.ld_data;
`endif
            end
            default: mem_we = 1'b0;
        endcase
    end

    // Storage has no reset; the CLEAR sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CLEAR;
            clr_ptr      <= '0;
            wr_ptr       <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.ld_done  <= 1'b0;
            bus.ld_count <= '0;
`ifdef PROG_MEM_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= fetch;
            bus.ld_done  <= ld_end;
            if (fetch) begin
                bus.rd_err  <= !in_range;
                bus.rd_data <= in_range ? rd_word[DATA_W-1:0] : '0;
            end else begin
                bus.rd_err  <= 1'b0;
            end
`ifdef PROG_MEM_PARITY_EN
            bus.parity_err <= fetch && in_range &&
                              (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
`endif
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_IDX) begin
                        clr_ptr <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        wr_ptr <= '0;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ld_accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (ld_end) begin
                        bus.ld_count <= (ADDR_W + 1)'(wr_ptr) + (ADDR_W + 1)'(1);
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: doc/program_memory_loadable.md
Name: program_memory_loadable

Overview:
- Parametrised successor to the fixed 8-bit program ROM: a writable program store with a synchronous read port for instruction fetch.
- Adds a streaming loader so programs are bootloaded at run time instead of fixed at elaboration.
- Zero-fills itself after reset, and flags fetches from out-of-range addresses.
- Sits between the instruction fetch/PC logic and the external program-load source.

Parameters:
- DATA_W, 8: word width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 128: number of implemented words; legal range 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  fetch request.
- rd_addr  input  ADDR_W  fetch address.
- rd_data  output  DATA_W  fetched word.
- rd_valid  output  1  rd_data updated this cycle.
- rd_err  output  1  the fetch that produced rd_valid had rd_addr >= DEPTH.
- ready  output  1  high only in IDLE; fetches are accepted only while it is high.
- ld_start  input  1  begin a load session.
- ld_valid  input  1  ld_data is valid.
- ld_data  input  DATA_W  word to store.
- ld_last  input  1  marks the final word of the session.
- ld_ready  output  1  loader accepts a word (LOAD state).
- ld_done  output  1  one-cycle pulse when a session ends.
- ld_count  output  ADDR_W+1  words written in the last completed session.

Behaviour:
- Reset (async assert, any state):
  - state = CLEAR, clr_ptr = 0, wr_ptr = 0.
  - rd_data = 0; rd_valid, rd_err, ld_done, ld_ready, ready = 0; ld_count = 0.
- CLEAR state:
  - Writes 0 to mem[clr_ptr] each cycle; clr_ptr increments.
  - After writing DEPTH-1, moves to IDLE; DEPTH cycles total.
  - rd_en, ld_start and ld_valid are ignored in this state.
- IDLE state, ready = 1:
  - A fetch is accepted when rd_en = 1.
  - Latency is 1 cycle: on the next edge rd_valid = 1.
  - If rd_addr < DEPTH: rd_data = mem[rd_addr], rd_err = 0.
  - Otherwise: rd_data = 0, rd_err = 1.
  - With no fetch: rd_valid = 0, rd_err = 0, rd_data holds its last value.
  - Back-to-back fetches give one result per cycle.
  - ld_start = 1 moves to LOAD with wr_ptr = 0. ld_start has priority: an rd_en in the same cycle is dropped (no rd_valid).
- LOAD state, ready = 0, ld_ready = 1:
  - On ld_valid & ld_ready: mem[wr_ptr] = ld_data, wr_ptr increments.
  - The session ends on the accepted word that has ld_last = 1, or on the word written at DEPTH-1 (auto-terminate; any further words are not accepted).
  - At session end: state goes to IDLE next cycle, ld_done pulses for 1 cycle, ld_count = number of words written (1..DEPTH).
  - Words beyond the session keep their previous contents.
  - ld_valid = 0 stalls the session indefinitely. ld_start is ignored.
- Fetch reads return the pre-write value when a load is in progress; fetches are blocked anyway while ready = 0.
- Reset in the middle of LOAD or CLEAR aborts the session: the block restarts CLEAR and the whole memory is zeroed.
- ld_done and rd_valid are registered outputs, never combinational.

Optional Feature:
- Macro: PROG_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on load writes; CLEAR writes parity 0.
  - An extra output parity_err (1 bit, reset 0) is asserted with rd_valid when the stored parity mismatches the stored data.
  - parity_err is 0 for out-of-range fetches.
- Undefined: no parity storage, no parity_err port; behaviour otherwise identical.

Test Plan:
- Reset-clear: assert rst, release, count cycles → ready rises after exactly 128 cycles; fetch of addr 0x05 → rd_valid = 1, rd_data = 0x00, rd_err = 0.
- Load then fetch: ld_start, stream 0x87, 0xF0, 0x42 (last on 0x42) → ld_done pulse, ld_count = 3; fetches of 0, 1, 2 back-to-back → 0x87, 0xF0, 0x42 on consecutive cycles, each one cycle after its request.
- Out of range: fetch rd_addr = 0x80 and 0xFF → rd_valid = 1, rd_err = 1, rd_data = 0x00; the next in-range fetch clears rd_err.
- Loader stall and auto-terminate: ld_valid toggled every other cycle, 128 words with ld_last never set → session ends after word 127, ld_count = 128, ld_ready = 0 afterwards.
- Priority and ignored inputs: ld_start and rd_en in the same IDLE cycle → no rd_valid, state goes to LOAD; ld_start during CLEAR → ignored.
- Reset mid-load: rst asserted after 2 of 4 words → outputs return to reset values, CLEAR runs again, and fetching addr 0 returns 0x00.
